// File: rtl/swift_link_pkg.sv
// Shared definitions for the ground-side EAGLE SWIPT2 link receiver.
// Holds the FSM state type, the stng/type field codes, the positions of each
// field inside the 20-bit decoded word, and the rule that maps a good frame
// to the number of answer pulses the drone expects back.
package swift_link_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RX,
    CHECK,
    ANS_WAIT,
    ANS_HI,
    ANS_LO
  } rx_state_t;

  // Setting (stng) codes
  localparam logic [1:0] STNG_STARTUP  = 2'b00;
  localparam logic [1:0] STNG_POWER    = 2'b01;
  localparam logic [1:0] STNG_DATA     = 2'b11;
  localparam logic [1:0] STNG_QUESTION = 2'b10;

  // Type codes
  localparam logic [1:0] TYPE_POWER = 2'b00;
  localparam logic [1:0] TYPE_EFF   = 2'b01;
  localparam logic [1:0] TYPE_IDC   = 2'b11;
  localparam logic [1:0] TYPE_VDC   = 2'b10;

  // Frame geometry: 20 Manchester symbols, two half-bits each
  localparam int FRAME_HALVES = 40;
  localparam int WORD_BITS    = 20;

  // Field positions inside the decoded word (bit 19 is sent first)
  localparam int STRT_MSB = 19;
  localparam int STRT_LSB = 17;
  localparam int STNG_MSB = 16;
  localparam int STNG_LSB = 15;
  localparam int TYPE_MSB = 14;
  localparam int TYPE_LSB = 13;
  localparam int DATA_MSB = 12;
  localparam int DATA_LSB = 3;
  localparam int END_MSB  = 2;
  localparam int END_LSB  = 0;

  // Number of answer pulses owed for a good frame. Only power frames look at
  // the host's power command: L up needs no pulse, L down one, optimum two.
  function automatic logic [1:0] answer_pulses(input logic [1:0] stng,
                                               input logic [1:0] pcmd);
    logic [1:0] n;
    n = 2'd0;
    case (stng)
      STNG_STARTUP:  n = 2'd1;
      STNG_QUESTION: n = 2'd1;
      STNG_POWER: begin
        if (pcmd == 2'd0)      n = 2'd0;
        else if (pcmd == 2'd1) n = 2'd1;
        else                   n = 2'd2;
      end
      default:       n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/manch_pair_decode.sv
// Combinational Manchester pair decoder.
// Ports:
//   halves  - 40 sampled half-bits, bit 39 is the first one received
//   word    - 20 decoded bits, word[i] comes from pair (halves[2i+1], halves[2i])
//   sym_err - high when any pair is 00 or 11
// A pair 01 decodes to 1 and 10 to 0, so the data bit is simply the second
// half of the pair; only the equality of the two halves needs checking.
module manch_pair_decode
  import swift_link_pkg::*;
(
  input  logic [FRAME_HALVES-1:0] halves,
  output logic [WORD_BITS-1:0]    word,
  output logic                    sym_err
);

  always_comb begin
    word    = '0;
    sym_err = 1'b0;
    for (int i = 0; i < WORD_BITS; i++) begin
      word[i] = halves[2*i];
      if (halves[2*i+1] == halves[2*i]) sym_err = 1'b1;
    end
  end

endmodule

// File: rtl/ground_link_rx.sv
// Ground-side receiver for the EAGLE SWIPT2 drone link.
// Detects a 40-half-bit Manchester frame on the sliced envelope bit, checks
// it, presents the stng/type/data fields with a one-cycle strobe and, for
// frames that need an answer, drives the answer pulse train on the power link.
// Ports:
//   clk, nrst (sync, active-low), rx_en (low = reset except frame_cnt/fields)
//   din_raw     - asynchronous envelope bit, 1 = modulated
//   power_cmd   - answer selection for power frames
//   frame_valid - strobe for a good frame, frame_err - strobe for a bad one
//   setting, dtype, data - fields of the last good frame
//   answer      - answer modulation drive
//   busy        - FSM not in IDLE
//   frame_cnt   - good-frame counter, wraps
module ground_link_rx
  import swift_link_pkg::*;
#(
  parameter int HALF_BIT  = 100001,
  parameter int ANS_DELAY = 600000,
  parameter int ANS_PULSE = 120000,
  parameter int ANS_GAP   = 120000,
  parameter int CW        = 24
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       rx_en,
  input  logic       din_raw,
  input  logic [1:0] power_cmd,
  output logic       frame_valid,
  output logic [1:0] setting,
  output logic [1:0] dtype,
  output logic [9:0] data,
  output logic       frame_err,
  output logic       answer,
  output logic       busy,
  output logic [7:0] frame_cnt
);

  localparam logic [CW-1:0] HB_START   = CW'(HALF_BIT / 2);
  localparam logic [CW-1:0] HB_RELOAD  = CW'(HALF_BIT - 1);
  // CHECK and the cycle that raises answer cover two of the ANS_DELAY clocks
  localparam logic [CW-1:0] WAIT_LOAD  = CW'(ANS_DELAY - 2);
  localparam logic [CW-1:0] PULSE_LOAD = CW'(ANS_PULSE - 1);
  localparam logic [CW-1:0] GAP_LOAD   = CW'(ANS_GAP - 1);
  localparam logic [CW-1:0] TMR_ONE    = CW'(1);
  localparam logic [5:0]    LAST_HALF  = 6'(FRAME_HALVES - 1);

  logic                    din_m;
  logic                    din_s;
  rx_state_t               state;
  logic                    armed;
  logic [CW-1:0]           tmr;
  logic [5:0]              hb_idx;
  logic [FRAME_HALVES-2:0] shift;
  logic [1:0]              ans_left;
  logic [FRAME_HALVES-1:0] dec_in;
  logic [WORD_BITS-1:0]    word;
  logic                    sym_err;
  logic                    frame_ok;

  // Two-flop synchronizer. Left unreset so din_s keeps tracking the line
  // through reset: a line held high at release must not look like a fresh edge.
  always_ff @(posedge clk) begin
    din_m <= din_raw;
    din_s <= din_m;
  end

  // The last half-bit is decoded straight from din_s in the cycle it is
  // sampled, so the fields and strobes are already registered during CHECK.
  assign dec_in = {shift, din_s};

  manch_pair_decode u_decode (
    .halves  (dec_in),
    .word    (word),
    .sym_err (sym_err)
  );

  assign frame_ok = !sym_err
                 && (word[STRT_MSB:STRT_LSB] == 3'b000)
                 && (word[END_MSB:END_LSB] == 3'b000);

  assign busy = (state != IDLE);

  // Receive / check / answer FSM with all timers and registered outputs
  always_ff @(posedge clk) begin
    if (!nrst || !rx_en) begin
      state       <= IDLE;
      armed       <= 1'b0;
      tmr         <= '0;
      hb_idx      <= '0;
      shift       <= '0;
      ans_left    <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      answer      <= 1'b0;
      if (!nrst) begin
        setting   <= '0;
        dtype     <= '0;
        data      <= '0;
        frame_cnt <= '0;
      end
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (!din_s) begin
            armed <= 1'b1;
          end else if (armed) begin
            armed  <= 1'b0;
            state  <= RX;
            tmr    <= HB_START;
            hb_idx <= LAST_HALF;
          end
        end

        RX: begin
          if (tmr == '0) begin
            shift <= {shift[FRAME_HALVES-3:0], din_s};
            tmr   <= HB_RELOAD;
            if (hb_idx == 6'd0) begin
              state <= CHECK;
              if (frame_ok) begin
                setting     <= word[STNG_MSB:STNG_LSB];
                dtype       <= word[TYPE_MSB:TYPE_LSB];
                data        <= word[DATA_MSB:DATA_LSB];
                frame_valid <= 1'b1;
                frame_cnt   <= frame_cnt + 8'd1;
              end else begin
                frame_err <= 1'b1;
              end
            end else begin
              hb_idx <= hb_idx - 6'd1;
            end
          end else begin
            tmr <= tmr - TMR_ONE;
          end
        end

        // frame_valid is high here exactly when the frame was good
        CHECK: begin
          armed <= 1'b0;
          if (frame_valid && (answer_pulses(setting, power_cmd) != 2'd0)) begin
            state    <= ANS_WAIT;
            tmr      <= WAIT_LOAD;
            ans_left <= answer_pulses(setting, power_cmd);
          end else begin
            state <= IDLE;
          end
        end

        ANS_WAIT: begin
          if (tmr == '0) begin
            state    <= ANS_HI;
            answer   <= 1'b1;
            tmr      <= PULSE_LOAD;
            ans_left <= ans_left - 2'd1;
          end else begin
            tmr <= tmr - TMR_ONE;
          end
        end

        ANS_HI: begin
          if (tmr == '0) begin
            state  <= ANS_LO;
            answer <= 1'b0;
            tmr    <= GAP_LOAD;
          end else begin
            tmr <= tmr - TMR_ONE;
          end
        end

        ANS_LO: begin
          if (tmr == '0) begin
            if (ans_left == 2'd0) begin
              state <= IDLE;
              armed <= 1'b0;
            end else begin
              state    <= ANS_HI;
              answer   <= 1'b1;
              tmr      <= PULSE_LOAD;
              ans_left <= ans_left - 2'd1;
            end
          end else begin
            tmr <= tmr - TMR_ONE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
